// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter
//   Two-master Wishbone arbiter in front of a single-slave main memory.
//   Master 0 is the core port, master 1 the loader/DMA port. Ownership is
//   decided round-robin once per bus cycle and held until the owner drops cyc.
//   Every new bus cycle passes through IDLE for one arbitration cycle.
//
//   Optional feature: define WB_ARB_TIMEOUT_EN to build in a watchdog that
//   terminates an access stalled for TIMEOUT_CYCLES cycles with a one-cycle
//   error pulse to the owning master.
module wb_mem_arbiter #(
  parameter int WB_DWIDTH      = 32,
  parameter int WB_SWIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,

  // Master 0 (core)
  input  logic [31:0]          i_m0_adr,
  input  logic [WB_SWIDTH-1:0] i_m0_sel,
  input  logic                 i_m0_we,
  input  logic [WB_DWIDTH-1:0] i_m0_dat,
  input  logic                 i_m0_cyc,
  input  logic                 i_m0_stb,
  output logic [WB_DWIDTH-1:0] o_m0_dat,
  output logic                 o_m0_ack,
  output logic                 o_m0_err,

  // Master 1 (loader / DMA)
  input  logic [31:0]          i_m1_adr,
  input  logic [WB_SWIDTH-1:0] i_m1_sel,
  input  logic                 i_m1_we,
  input  logic [WB_DWIDTH-1:0] i_m1_dat,
  input  logic                 i_m1_cyc,
  input  logic                 i_m1_stb,
  output logic [WB_DWIDTH-1:0] o_m1_dat,
  output logic                 o_m1_ack,
  output logic                 o_m1_err,

  // Slave (main memory)
  output logic [31:0]          o_s_adr,
  output logic [WB_SWIDTH-1:0] o_s_sel,
  output logic                 o_s_we,
  output logic [WB_DWIDTH-1:0] o_s_dat,
  output logic                 o_s_cyc,
  output logic                 o_s_stb,
  input  logic [WB_DWIDTH-1:0] i_s_dat,
  input  logic                 i_s_ack,
  input  logic                 i_s_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;   // last master granted; 1 after reset so m0 wins the first tie
  logic   req0, req1;
  logic   timeout;          // watchdog expiry, constant 0 when not built in

  // Elaboration-time parameter sanity
  if (TIMEOUT_CYCLES < 4 || WB_SWIDTH != WB_DWIDTH / 8) begin : g_param_check
    $error("wb_mem_arbiter: TIMEOUT_CYCLES must be >= 4 and WB_SWIDTH = WB_DWIDTH/8");
  end

  assign req0 = i_m0_cyc & i_m0_stb;
  assign req1 = i_m1_cyc & i_m1_stb;

  // Arbitration: pick a requester from IDLE, release the grant when cyc drops
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (req0 && (!req1 || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: if (!i_m0_cyc) state_d = IDLE;
      GNT1: if (!i_m1_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin pointer registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            owner_stb;

  assign owner_stb = (state_q == GNT0) ? i_m0_stb :
                     (state_q == GNT1) ? i_m1_stb : 1'b0;

  assign timeout = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES));

  // Watchdog: count stalled strobe cycles, clear on any termination or grant change
  always_comb begin
    wd_d = wd_q;
    if (state_q == IDLE || state_d != state_q || timeout || i_s_ack || i_s_err) begin
      wd_d = '0;
    end else if (owner_stb) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Routing: slave request from the owner, slave response to the owner only.
  // Outputs derive from state_q alone, so asserting reset clears them at once.
  always_comb begin
    o_s_adr  = '0;
    o_s_sel  = '0;
    o_s_we   = 1'b0;
    o_s_dat  = '0;
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_m0_dat = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_dat = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    unique case (state_q)
      GNT0: begin
        o_s_adr  = i_m0_adr;
        o_s_sel  = i_m0_sel;
        o_s_we   = i_m0_we;
        o_s_dat  = i_m0_dat;
        o_s_cyc  = i_m0_cyc;
        o_s_stb  = i_m0_stb & ~timeout;
        o_m0_dat = i_s_dat;
        o_m0_ack = i_s_ack;
        o_m0_err = i_s_err | timeout;
      end
      GNT1: begin
        o_s_adr  = i_m1_adr;
        o_s_sel  = i_m1_sel;
        o_s_we   = i_m1_we;
        o_s_dat  = i_m1_dat;
        o_s_cyc  = i_m1_cyc;
        o_s_stb  = i_m1_stb & ~timeout;
        o_m1_dat = i_s_dat;
        o_m1_ack = i_s_ack;
        o_m1_err = i_s_err | timeout;
      end
      default: ;
    endcase
  end

endmodule
